// File: rtl/ofmap_writeback.sv
// Packs upstream ofmap results (int8 x4 or 32-bit pass-through) into a small FIFO
// and streams them to DRAM over a valid/ready write channel at incrementing byte addresses.
module ofmap_writeback #(
   parameter int DATA_SIZE  = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic                 wide,
   input  logic                 in_valid,
   input  logic [DATA_SIZE-1:0] in_data,
   input  logic                 in_done,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ADDR_W-1:0]    out_addr,
   output logic [DATA_SIZE-1:0] out_data,
   output logic [3:0]           out_strb,
   output logic                 busy,
   output logic                 finished,
   output logic                 overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {IDLE, COLLECT, FLUSH, DRAIN, DONE} state_t;

   state_t               state;
   logic [DATA_SIZE-1:0] mem_data [FIFO_DEPTH];
   logic [3:0]           mem_strb [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        count;
   logic [ADDR_W-1:0]    addr_reg;
   logic                 wide_reg;
   logic [23:0]          pack;      // bytes 0..2 of the word being assembled; unused bytes kept zero
   logic [1:0]           byte_cnt;

   logic                 push, pop, full, wr_en;
   logic [DATA_SIZE-1:0] push_data;
   logic [3:0]           push_strb;

   assign full      = (count == CW'(FIFO_DEPTH));
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign wr_en     = push && (!full || pop);
   assign out_addr  = addr_reg;
   assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
   assign out_strb  = out_valid ? mem_strb[rd_ptr] : 4'b0000;
   assign busy      = (state != IDLE);

   always_comb begin
      push      = 1'b0;
      push_data = '0;
      push_strb = 4'b0000;
      case (state)
         COLLECT: begin
            if (in_valid) begin
               if (wide_reg) begin
                  push      = 1'b1;
                  push_data = in_data;
                  push_strb = 4'b1111;
               end else if (byte_cnt == 2'd3) begin
                  push      = 1'b1;
                  push_data = DATA_SIZE'({in_data[7:0], pack});
                  push_strb = 4'b1111;
               end
            end
         end
         FLUSH: begin
            if (byte_cnt != 2'd0) begin
               push      = 1'b1;
               push_data = DATA_SIZE'({8'h00, pack});
               push_strb = (4'b0001 << byte_cnt) - 4'b0001;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_data[wr_ptr] <= push_data;
         mem_strb[wr_ptr] <= push_strb;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         addr_reg <= '0;
         wide_reg <= 1'b0;
         pack     <= '0;
         byte_cnt <= 2'd0;
         overflow <= 1'b0;
         finished <= 1'b0;
      end else begin
         finished <= 1'b0;
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr   <= rd_ptr + AW'(1);
            addr_reg <= addr_reg + ADDR_W'(4);
         end
         case ({wr_en, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
         if (push && !wr_en) overflow <= 1'b1;

         case (state)
            IDLE: begin
               if (start) begin
                  addr_reg <= base_addr;
                  wide_reg <= wide;
                  overflow <= 1'b0;
                  pack     <= '0;
                  byte_cnt <= 2'd0;
                  state    <= COLLECT;
               end
            end
            COLLECT: begin
               if (in_valid && !wide_reg) begin
                  if (byte_cnt == 2'd3) begin
                     pack     <= '0;
                     byte_cnt <= 2'd0;
                  end else begin
                     pack[{byte_cnt, 3'b000} +: 8] <= in_data[7:0];
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end
               if (in_done) state <= FLUSH;
            end
            FLUSH: begin
               if (in_valid) overflow <= 1'b1;
               pack     <= '0;
               byte_cnt <= 2'd0;
               state    <= DRAIN;
            end
            DRAIN: begin
               if (in_valid) overflow <= 1'b1;
               if (count == '0) begin
                  finished <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               if (in_valid) overflow <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
